// File: rtl/vram_scan_arbiter.sv
// Shares a single-port frame-buffer RAM between upscaled VGA scanout reads (absolute priority) and
// game-logic writes to the back buffer; a requested front/back swap commits on the first vblank cycle.
module vram_scan_arbiter #(
    parameter int HWIDTH = 12,
    parameter int VWIDTH = 12,
    parameter int HSIZE  = 640,
    parameter int VSIZE  = 480,
    parameter int S      = 2,
    parameter int FB_AW  = 15,
    parameter int DW     = 12,
    parameter bit HSPP   = 1'b1,
    parameter bit VSPP   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HWIDTH-1:0] hdata,
    input  logic [VWIDTH-1:0] vdata,
    input  logic              valid,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [FB_AW-1:0]  wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_sel,
    output logic [15:0]       frame_cnt,
    output logic [FB_AW:0]    mem_addr,
    output logic              mem_we,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic [DW-1:0]     pix_rgb,
    output logic              de_o,
    output logic              hsync_o,
    output logic              vsync_o
);

    localparam int FB_W = HSIZE >> S;

    logic             scan_rd;
    logic             wr_accept;
    logic             frame_event;
    logic [FB_AW-1:0] scan_word;
    logic             rd_d1, rd_d2;
    logic             vld_d1, vld_d2;
    logic             hs_d1, hs_d2;
    logic             vs_d1, vs_d2;

    // One read per 2^S-wide column group; every other cycle of the line is free for writes.
    assign scan_rd     = valid && (hdata[S-1:0] == '0);
    assign wr_ready    = !rst && !scan_rd;
    assign wr_accept   = wr_valid && wr_ready;
    assign frame_event = (hdata == '0) && (vdata == VWIDTH'(VSIZE));
    assign scan_word   = FB_AW'(vdata >> S) * FB_AW'(FB_W) + FB_AW'(hdata >> S);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= wr_accept;
            if (scan_rd) begin
                mem_addr <= {front_sel, scan_word};
            end else if (wr_accept) begin
                mem_addr  <= {~front_sel, wr_addr};
                mem_wdata <= wr_data;
            end
        end
    end

    // Timing flags ride alongside the RAM access so the pixel and its syncs leave together.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_d1   <= 1'b0;
            rd_d2   <= 1'b0;
            vld_d1  <= 1'b0;
            vld_d2  <= 1'b0;
            hs_d1   <= !HSPP;
            hs_d2   <= !HSPP;
            vs_d1   <= !VSPP;
            vs_d2   <= !VSPP;
            de_o    <= 1'b0;
            hsync_o <= !HSPP;
            vsync_o <= !VSPP;
            pix_rgb <= '0;
        end else begin
            rd_d1   <= scan_rd;
            rd_d2   <= rd_d1;
            vld_d1  <= valid;
            vld_d2  <= vld_d1;
            hs_d1   <= hsync;
            hs_d2   <= hs_d1;
            vs_d1   <= vsync;
            vs_d2   <= vs_d1;
            de_o    <= vld_d2;
            hsync_o <= hs_d2;
            vsync_o <= vs_d2;
            if (!vld_d2) begin
                pix_rgb <= '0;
            end else if (rd_d2) begin
                pix_rgb <= mem_rdata;
            end
        end
    end

    // A write accepted on the swap cycle still targets the old back buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            front_sel <= 1'b0;
            frame_cnt <= '0;
            swap_ack  <= 1'b0;
        end else begin
            swap_ack <= frame_event && swap_req;
            if (frame_event) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (swap_req) begin
                    front_sel <= ~front_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Scoreboard bench for vram_scan_arbiter: stimulus pushes expected responses, a negedge monitor
// pops and compares them when the DUT presents pixels, writes and per-cycle state.
module tb_vram_scan_arbiter;

    logic        clk;
    logic        rst;
    logic [11:0] hdata;
    logic [11:0] vdata;
    logic        valid;
    logic        hsync;
    logic        vsync;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        swap_req;
    logic        swap_ack;
    logic        front_sel;
    logic [15:0] frame_cnt;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [11:0] pix_rgb;
    logic        de_o;
    logic        hsync_o;
    logic        vsync_o;

    vram_scan_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .hdata     (hdata),
        .vdata     (vdata),
        .valid     (valid),
        .hsync     (hsync),
        .vsync     (vsync),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .swap_req  (swap_req),
        .swap_ack  (swap_ack),
        .front_sel (front_sel),
        .frame_cnt (frame_cnt),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_rgb   (pix_rgb),
        .de_o      (de_o),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-buffer RAM: buffer 0 word k holds k, buffer 1 word k holds ~k.
    logic [11:0] ram [0:65535];
    initial begin
        for (int k = 0; k < 19200; k++) begin
            ram[k]         = 12'(k);
            ram[32768 + k] = ~12'(k);
        end
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct packed {
        logic        we;
        logic        rd_chk;
        logic [15:0] rd_addr;
        logic        front;
        logic [15:0] cnt;
        logic        ack;
    } state_t;

    state_t      stateQ [$];
    logic [2:0]  syncQ  [$];
    logic        readyQ [$];
    logic [11:0] pixQ   [$];
    logic [27:0] wrQ    [$];

    int          assertCount = 0;
    int          failCount   = 0;
    bit          monOn       = 1'b0;
    logic        expFront    = 1'b0;
    logic [15:0] expCnt      = 16'd0;
    logic [11:0] curPix      = 12'd0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        assertCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [11:0] expPix(input logic buffer, input int word);
        return buffer ? ~12'(word) : 12'(word);
    endfunction

    // Drives one pixel-clock cycle and records what the DUT must answer for it.
    task automatic applyStimulus(input int h, input int v, input bit vld, input bit hs, input bit vs,
                                 input bit wv, input int wa, input int wd, input bit sw);
        bit     scan, accept;
        int     word;
        state_t st;
        hdata    = 12'(h);
        vdata    = 12'(v);
        valid    = vld;
        hsync    = hs;
        vsync    = vs;
        wr_valid = wv;
        wr_addr  = 15'(wa);
        wr_data  = 12'(wd);
        swap_req = sw;
        scan   = vld && (h % 4 == 0);
        word   = (v / 4) * 160 + h / 4;
        accept = wv && !scan;
        readyQ.push_back(!scan);
        if (accept) wrQ.push_back({~expFront, 15'(wa), 12'(wd)});
        if (vld) begin
            if (scan) curPix = expPix(expFront, word);
            pixQ.push_back(curPix);
        end
        syncQ.push_back({vld, hs, vs});
        st.we      = accept;
        st.rd_chk  = scan;
        st.rd_addr = {expFront, 15'(word)};
        st.ack     = 1'b0;
        if (h == 0 && v == 480) begin
            expCnt = expCnt + 16'd1;
            st.ack = sw;
            if (sw) expFront = ~expFront;
        end
        st.front = expFront;
        st.cnt   = expCnt;
        stateQ.push_back(st);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int cycles);
        rst = 1'b1;
        #1;
        checkOutput("wr_ready_in_reset", wr_ready, 0);
        repeat (cycles) @(posedge clk);
        #1;
        stateQ.delete();
        syncQ.delete();
        readyQ.delete();
        pixQ.delete();
        expFront = 1'b0;
        expCnt   = 16'd0;
        curPix   = 12'd0;
        monOn    = 1'b1;
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_pix_rgb", pix_rgb, 0);
        checkOutput("rst_de_o", de_o, 0);
        checkOutput("rst_hsync_o", hsync_o, 0);
        checkOutput("rst_vsync_o", vsync_o, 0);
        checkOutput("rst_front_sel", front_sel, 0);
        checkOutput("rst_frame_cnt", frame_cnt, 0);
        checkOutput("rst_swap_ack", swap_ack, 0);
        rst = 1'b0;
    endtask

    // Monitor: compares whatever the DUT presents against the oldest matching expectation.
    always @(negedge clk) begin
        state_t     st;
        logic [2:0] sy;
        logic [27:0] wr;
        if (readyQ.size() >= 1) checkOutput("wr_ready", wr_ready, readyQ.pop_front());
        if (stateQ.size() >= 2) begin
            st = stateQ.pop_front();
            checkOutput("mem_we", mem_we, st.we);
            checkOutput("front_sel", front_sel, st.front);
            checkOutput("frame_cnt", frame_cnt, st.cnt);
            checkOutput("swap_ack", swap_ack, st.ack);
            if (st.rd_chk) checkOutput("scan_mem_addr", mem_addr, st.rd_addr);
        end
        if (syncQ.size() >= 4) begin
            sy = syncQ.pop_front();
            checkOutput("de_o", de_o, sy[2]);
            checkOutput("hsync_o", hsync_o, sy[1]);
            checkOutput("vsync_o", vsync_o, sy[0]);
        end
        if (mem_we === 1'b1) begin
            if (wrQ.size() == 0) begin
                checkOutput("unexpected_write", 1, 0);
            end else begin
                wr = wrQ.pop_front();
                checkOutput("wr_mem_addr", mem_addr, wr[27:12]);
                checkOutput("wr_mem_wdata", mem_wdata, wr[11:0]);
            end
        end
        if (de_o === 1'b1) begin
            if (pixQ.size() == 0) checkOutput("unexpected_pixel", 1, 0);
            else checkOutput("pix_rgb", pix_rgb, pixQ.pop_front());
        end else if (monOn) begin
            checkOutput("blank_pix_rgb", pix_rgb, 0);
        end
    end

    initial begin
        rst = 1'b1;
        hdata = '0; vdata = '0; valid = 1'b0; hsync = 1'b0; vsync = 1'b0;
        wr_valid = 1'b1; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
        doReset(3);

        // Plain scanout of line 0, hblank with an hsync pulse.
        for (int h = 0; h < 16; h++) applyStimulus(h, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int h = 640; h < 664; h++) applyStimulus(h, 0, 0, (h >= 648 && h < 656), 0, 0, 0, 0, 0);

        // Line 4: hdata=8 reads word 162, repeated for four columns.
        for (int h = 0; h < 24; h++) applyStimulus(h, 4, 1, 0, 0, 0, 0, 0, 0);

        // Writes held during the active line and through hblank.
        for (int h = 0; h < 16; h++) applyStimulus(h, 8, 1, 0, 0, 1, 1000 + h, 12'h100 + h, 0);
        for (int h = 640; h < 664; h++) applyStimulus(h, 8, 0, 0, 0, 1, 1100 + h - 640, 12'h200 + h - 640, 0);

        // Frame boundary without a swap request, then a vsync pulse.
        applyStimulus(0, 480, 0, 0, 0, 0, 0, 0, 0);
        for (int h = 1; h < 9; h++) applyStimulus(h, 480, 0, 0, 0, 0, 0, 0, 0);
        for (int h = 0; h < 8; h++) applyStimulus(h, 490, 0, 0, 1, 0, 0, 0, 0);

        // Swap requested during line 100, committed at the boundary with a concurrent write.
        for (int h = 0; h < 8; h++) applyStimulus(h, 100, 1, 0, 0, 0, 0, 0, 1);
        for (int h = 640; h < 648; h++) applyStimulus(h, 100, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 480, 0, 0, 0, 1, 2000, 12'hABC, 1);
        for (int h = 1; h < 6; h++) applyStimulus(h, 480, 0, 0, 0, 0, 0, 0, 1);
        for (int h = 0; h < 8; h++) applyStimulus(h, 0, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus(640, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 480, 0, 0, 0, 0, 0, 0, 0);
        for (int h = 1; h < 5; h++) applyStimulus(h, 480, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("boundary_write_in_buffer1", ram[32768 + 2000], 12'hABC);
        checkOutput("front_after_swaps", front_sel, 1);
        checkOutput("frame_cnt_after_3", frame_cnt, 3);

        // Reset while a write is in flight mid-line.
        for (int h = 0; h < 4; h++) applyStimulus(h, 10, 1, 0, 0, 1, 3000 + h, 12'h300 + h, 0);
        doReset(1);

        for (int h = 0; h < 8; h++) applyStimulus(h, 4, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(700, 20, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pixels_drained", pixQ.size(), 0);
        checkOutput("writes_drained", wrQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
